// File: rtl/yellow_frame_tracker.sv
// Per-frame yellow pixel counter for an RGB444 raster stream.
// Define YELLOW_BBOX_EN to also track the yellow bounding box.
module yellow_frame_tracker #(
    parameter int         H_RES     = 640,
    parameter int         V_RES     = 480,
    parameter logic [7:0] R_TH      = 8'd200,
    parameter logic [7:0] G_TH      = 8'd200,
    parameter logic [7:0] B_MAX     = 8'd120,
    parameter int         MIN_COUNT = 16,
    localparam int        CNT_W     = $clog2(H_RES*V_RES+1),
    localparam int        XW        = $clog2(H_RES),
    localparam int        YW        = $clog2(V_RES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [11:0]      pix_rgb444,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_found,
    output logic [CNT_W-1:0] res_count,
    output logic [XW-1:0]    res_xmin,
    output logic [XW-1:0]    res_xmax,
    output logic [YW-1:0]    res_ymin,
    output logic [YW-1:0]    res_ymax,
    output logic             frame_drop
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    logic [0:0]       state;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [CNT_W-1:0] cnt_q;

    logic [7:0] r8, g8, b8;
    logic       is_yellow;
    logic       sof, take, hit, last, x_end;
    logic       can_load, publish;
    logic [XW-1:0]    px;
    logic [YW-1:0]    py;
    logic [CNT_W-1:0] cnt_base, cnt_next;

    assign r8 = {pix_rgb444[11:8], pix_rgb444[11:8]};
    assign g8 = {pix_rgb444[7:4], pix_rgb444[7:4]};
    assign b8 = {pix_rgb444[3:0], pix_rgb444[3:0]};

    assign is_yellow = (r8 >= R_TH) && (g8 >= G_TH) && (b8 <= B_MAX);

    // A qualified sof always restarts the frame at (0,0), even mid-scan.
    assign sof   = pix_valid && pix_sof;
    assign take  = sof || (pix_valid && state == SCAN);
    assign px    = sof ? '0 : x_q;
    assign py    = sof ? '0 : y_q;
    assign x_end = (px == X_LAST);
    assign last  = take && !sof && x_end && (py == Y_LAST);
    assign hit   = take && is_yellow;

    assign cnt_base = sof ? '0 : cnt_q;
    assign cnt_next = (hit && cnt_base != '1) ? cnt_base + CNT_W'(1) : cnt_base;

    assign publish  = last;
    assign can_load = !res_valid || res_ready;

    // Raster position, scan state and yellow count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
        end else if (take) begin
            if (last) begin
                state <= IDLE;
                x_q   <= '0;
                y_q   <= '0;
                cnt_q <= '0;
            end else begin
                state <= SCAN;
                x_q   <= x_end ? '0 : px + XW'(1);
                y_q   <= x_end ? py + YW'(1) : py;
                cnt_q <= cnt_next;
            end
        end
    end

    // Result registers and handshake; a busy output drops the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_found  <= 1'b0;
            res_count  <= '0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= publish && !can_load;
            if (publish && can_load) begin
                res_valid <= 1'b1;
                res_count <= cnt_next;
                res_found <= (cnt_next >= CNT_W'(MIN_COUNT));
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef YELLOW_BBOX_EN
    logic [XW-1:0] xmin_q, xmax_q, xmin_b, xmax_b, xmin_n, xmax_n;
    logic [YW-1:0] ymin_q, ymax_q, ymin_b, ymax_b, ymin_n, ymax_n;

    assign xmin_b = sof ? X_LAST : xmin_q;
    assign xmax_b = sof ? '0 : xmax_q;
    assign ymin_b = sof ? Y_LAST : ymin_q;
    assign ymax_b = sof ? '0 : ymax_q;

    assign xmin_n = (hit && px < xmin_b) ? px : xmin_b;
    assign xmax_n = (hit && px > xmax_b) ? px : xmax_b;
    assign ymin_n = (hit && py < ymin_b) ? py : ymin_b;
    assign ymax_n = (hit && py > ymax_b) ? py : ymax_b;

    // Bounding box accumulators, re-armed to an empty box per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
        end else if (take) begin
            if (last) begin
                xmin_q <= X_LAST;
                xmax_q <= '0;
                ymin_q <= Y_LAST;
                ymax_q <= '0;
            end else begin
                xmin_q <= xmin_n;
                xmax_q <= xmax_n;
                ymin_q <= ymin_n;
                ymax_q <= ymax_n;
            end
        end
    end

    // Published bounding box, loaded alongside the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_xmin <= '0;
            res_xmax <= '0;
            res_ymin <= '0;
            res_ymax <= '0;
        end else if (publish && can_load) begin
            res_xmin <= xmin_n;
            res_xmax <= xmax_n;
            res_ymin <= ymin_n;
            res_ymax <= ymax_n;
        end
    end
`else
    assign res_xmin = '0;
    assign res_xmax = '0;
    assign res_ymin = '0;
    assign res_ymax = '0;
`endif

endmodule

// File: tb/tb_yellow_frame_tracker.sv
// Self-checking bench for yellow_frame_tracker on an 8x4 raster.
// Bbox checks follow YELLOW_BBOX_EN; otherwise the bbox ports must read 0.
module tb_yellow_frame_tracker;

    localparam int H = 8;
    localparam int V = 4;
    localparam int N = H * V;
    localparam int MINC = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid, pix_sof, res_ready;
    logic [11:0] pix_rgb444;
    logic        res_valid, res_found, frame_drop;
    logic [5:0]  res_count;
    logic [2:0]  res_xmin, res_xmax;
    logic [1:0]  res_ymin, res_ymax;

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;
    int res_seen = 0;

    logic [11:0] frame [N];

    typedef struct {
        logic [11:0] rgb;
        int          exp_count;
    } vec_t;

    vec_t tbl [8];

    yellow_frame_tracker #(
        .H_RES(H), .V_RES(V), .MIN_COUNT(MINC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_rgb444(pix_rgb444),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_found(res_found), .res_count(res_count),
        .res_xmin(res_xmin), .res_xmax(res_xmax),
        .res_ymin(res_ymin), .res_ymax(res_ymax),
        .frame_drop(frame_drop)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the active edge (pre-update values)
    always @(posedge clk) begin
        if (frame_drop) drop_cnt++;
        if (res_valid && res_ready) res_seen++;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit is_yellow(input logic [11:0] c);
        int r, g, b;
        r = int'(c[11:8]) * 17;
        g = int'(c[7:4]) * 17;
        b = int'(c[3:0]) * 17;
        return (r >= 200) && (g >= 200) && (b <= 120);
    endfunction

    task automatic model(output int c, output int x0, output int x1,
                         output int y0, output int y1);
        c = 0; x0 = H - 1; x1 = 0; y0 = V - 1; y1 = 0;
        for (int i = 0; i < N; i++) begin
            if (is_yellow(frame[i])) begin
                c++;
                if (i % H < x0) x0 = i % H;
                if (i % H > x1) x1 = i % H;
                if (i / H < y0) y0 = i / H;
                if (i / H > y1) y1 = i / H;
            end
        end
    endtask

    task automatic expect_res(input string nm, input int c, input int x0,
                              input int x1, input int y0, input int y1);
        check({nm, ".valid"}, res_valid, 1);
        check({nm, ".count"}, res_count, c);
        check({nm, ".found"}, res_found, c >= MINC);
`ifdef YELLOW_BBOX_EN
        check({nm, ".xmin"}, res_xmin, x0);
        check({nm, ".xmax"}, res_xmax, x1);
        check({nm, ".ymin"}, res_ymin, y0);
        check({nm, ".ymax"}, res_ymax, y1);
`else
        check({nm, ".bbox"}, {res_xmin, res_xmax, res_ymin, res_ymax}, 0);
`endif
    endtask

    task automatic drive(input bit v, input bit s, input logic [11:0] c);
        @(negedge clk);
        pix_valid  = v;
        pix_sof    = s;
        pix_rgb444 = c;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 12'h000);
    endtask

    // Streams frame[]; returns on the first negedge after the last pixel
    task automatic run_frame(input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) drive(0, 0, 12'h000);
            drive(1, i == 0, frame[i]);
        end
        drive(0, 0, 12'h000);
    endtask

    task automatic fill(input logic [11:0] c);
        for (int i = 0; i < N; i++) frame[i] = c;
    endtask

    initial begin
        int c, x0, x1, y0, y1, rs0, d0;

        tbl[0] = '{12'hCC7, 32};
        tbl[1] = '{12'hBC7, 0};
        tbl[2] = '{12'hCB7, 0};
        tbl[3] = '{12'hCC8, 0};
        tbl[4] = '{12'hFF0, 32};
        tbl[5] = '{12'h000, 0};
        tbl[6] = '{12'hFFF, 0};
        tbl[7] = '{12'hDE5, 32};

        rst_n = 1'b0; pix_valid = 0; pix_sof = 0;
        pix_rgb444 = 0; res_ready = 1;
        idle(2);
        check("reset.valid", res_valid, 0);
        check("reset.count", res_count, 0);
        check("reset.found", res_found, 0);
        check("reset.drop", frame_drop, 0);
        check("reset.bbox", {res_xmin, res_xmax, res_ymin, res_ymax}, 0);
        rst_n = 1'b1;
        idle(2);

        // 1: all black, latency exactly one cycle, valid drops after accept
        fill(12'h000);
        run_frame(0);
        expect_res("black", 0, H - 1, 0, V - 1, 0);
        idle(1);
        check("black.valid_drop", res_valid, 0);

        // 2: three yellow pixels in a blue frame
        fill(12'h00F);
        frame[10] = 12'hFF0;
        frame[13] = 12'hFF0;
        frame[19] = 12'hFF0;
        run_frame(0);
        expect_res("three", 3, 2, 5, 1, 2);
        idle(2);

        // 3: thresholds and edge colours, full frames
        for (int k = 0; k < 8; k++) begin
            fill(tbl[k].rgb);
            run_frame(0);
            if (tbl[k].exp_count == N)
                expect_res($sformatf("tbl%0d", k), N, 0, H - 1, 0, V - 1);
            else
                expect_res($sformatf("tbl%0d", k), 0, H - 1, 0, V - 1, 0);
            idle(1);
        end

        // 4: consumer stalled across two frames
        res_ready = 0;
        d0 = drop_cnt;
        fill(12'h000);
        frame[0] = 12'hFF0; frame[9] = 12'hFF0; frame[31] = 12'hFF0;
        run_frame(0);
        expect_res("stallA", 3, 0, 7, 0, 3);
        check("stallA.drop", frame_drop, 0);
        fill(12'hFF0);
        run_frame(1);
        check("stallB.drop_pulse", frame_drop, 1);
        check("stallB.held_count", res_count, 3);
        idle(2);
        check("stallB.drop_once", drop_cnt - d0, 1);
        check("stallB.valid_held", res_valid, 1);
        check("stallB.still_count", res_count, 3);
        res_ready = 1;
        idle(2);
        check("stall.valid_drop", res_valid, 0);

        // 5: sof mid-frame at (4,2) restarts; no result from the partial
        rs0 = res_seen;
        d0  = drop_cnt;
        for (int i = 0; i < 20; i++) drive(1, i == 0, 12'hFF0);
        fill(12'h000);
        for (int i = 0; i < 5; i++) frame[i * 6] = 12'hEE0;
        run_frame(0);
        model(c, x0, x1, y0, y1);
        expect_res("abort", c, x0, x1, y0, y1);
        check("abort.count5", res_count, 5);
        idle(2);
        check("abort.results", res_seen - rs0, 1);
        check("abort.drops", drop_cnt - d0, 0);

        // 5b: sof landing on the last-pixel slot restarts instead of ending
        rs0 = res_seen;
        for (int i = 0; i < N - 1; i++) drive(1, i == 0, 12'hFF0);
        fill(12'h000);
        frame[0] = 12'hFF0; frame[31] = 12'hFF0;
        run_frame(0);
        expect_res("lastsof", 2, 0, 7, 0, 3);
        idle(2);
        check("lastsof.results", res_seen - rs0, 1);

        // 6: async reset mid-frame with a pending result
        res_ready = 0;
        fill(12'hFF0);
        run_frame(0);
        check("rst.pending", res_valid, 1);
        for (int i = 0; i < 10; i++) drive(1, i == 0, 12'hFF0);
        @(negedge clk);
        pix_valid = 0;
        rst_n = 1'b0;
        #1;
        check("rst.valid", res_valid, 0);
        check("rst.count", res_count, 0);
        check("rst.found", res_found, 0);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1;
        rs0 = res_seen;
        for (int i = 0; i < 40; i++) drive(1, 0, 12'hFF0);
        idle(2);
        check("rst.ignored", res_seen - rs0, 0);
        check("rst.no_valid", res_valid, 0);
        fill(12'h00F);
        frame[7] = 12'hFF0; frame[24] = 12'hFF0;
        frame[8] = 12'hFF0; frame[15] = 12'hFF0;
        run_frame(0);
        expect_res("rst.after", 4, 0, 7, 0, 3);
        idle(1);

        // Random frames with input gaps against the model
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0: frame[i] = 12'hCC7;
                    1: frame[i] = 12'hBC7;
                    2: frame[i] = 12'hCC8;
                    3: frame[i] = 12'hFD0;
                    default: frame[i] = 12'($urandom);
                endcase
            end
            run_frame(1);
            model(c, x0, x1, y0, y1);
            expect_res($sformatf("rand%0d", f), c, x0, x1, y0, y1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
